// File: rtl/prbs_ber_checker.sv
// Self-synchronising PRBS-7 (x^7+x^6+1) bit-error-rate checker with saturating counters.
// Optional loss-of-sync detection is compiled in when BER_LOS_EN is defined.
module prbs_ber_checker #(
  parameter int CNT_W    = 32,
  parameter int SYNC_LEN = 16,
  parameter int LOS_WIN  = 64,
  parameter int LOS_ERR  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_vld,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             bit_sat,
  output logic             err_sat
);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam int RUN_W = $clog2(SYNC_LEN + 1);

  logic [1:0]       state_reg, state_next;
  logic [6:0]       lf_reg, lf_next;
  logic [2:0]       fill_reg, fill_next;
  logic [RUN_W-1:0] run_reg, run_next;
  logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;
  logic             bit_sat_reg, bit_sat_next;
  logic             err_sat_reg, err_sat_next;
  logic             err_pulse_reg, err_pulse_next;

`ifdef BER_LOS_EN
  localparam int WIN_W  = $clog2(LOS_WIN);
  localparam int WERR_W = $clog2(LOS_ERR + 1);
  logic [WIN_W-1:0]  win_reg, win_next;
  logic [WERR_W-1:0] win_err_reg, win_err_next;
`endif

  logic       pred;
  logic       mism;
  logic [6:0] shift_din;
  logic [6:0] shift_pred;
  logic       cnt_bit;
  logic       cnt_err;

  assign pred       = lf_reg[6] ^ lf_reg[5];
  assign mism       = din ^ pred;
  assign shift_din  = {lf_reg[5:0], din};
  assign shift_pred = {lf_reg[5:0], pred};

  always_comb begin
    state_next     = state_reg;
    lf_next        = lf_reg;
    fill_next      = fill_reg;
    run_next       = run_reg;
    err_pulse_next = 1'b0;
    cnt_bit        = 1'b0;
    cnt_err        = 1'b0;
`ifdef BER_LOS_EN
    win_next       = win_reg;
    win_err_next   = win_err_reg;
`endif
    if (din_vld) begin
      case (state_reg)
        HUNT: begin
          lf_next = shift_din;
          if (fill_reg == 3'd6) begin
            // All-zero is the LFSR lock-up state, so keep hunting on it
            fill_next = 3'd0;
            run_next  = '0;
            if (shift_din != 7'd0) state_next = CHECK;
          end else begin
            fill_next = fill_reg + 3'd1;
          end
        end
        CHECK: begin
          lf_next = shift_pred;
          if (!mism) begin
            if (run_reg == RUN_W'(SYNC_LEN - 1)) begin
              state_next = LOCKED;
              run_next   = '0;
`ifdef BER_LOS_EN
              win_next     = '0;
              win_err_next = '0;
`endif
            end else begin
              run_next = run_reg + 1'b1;
            end
          end else begin
            state_next = HUNT;
            fill_next  = 3'd0;
            run_next   = '0;
          end
        end
        LOCKED: begin
          // Free-run on the prediction so a bad bit never corrupts the reference
          lf_next        = shift_pred;
          cnt_bit        = 1'b1;
          cnt_err        = mism;
          err_pulse_next = mism;
`ifdef BER_LOS_EN
          if (mism && (win_err_reg == WERR_W'(LOS_ERR - 1))) begin
            state_next   = HUNT;
            fill_next    = 3'd0;
            run_next     = '0;
            win_next     = '0;
            win_err_next = '0;
          end else if (win_reg == WIN_W'(LOS_WIN - 1)) begin
            win_next     = '0;
            win_err_next = '0;
          end else begin
            win_next     = win_reg + 1'b1;
            win_err_next = win_err_reg + {{(WERR_W-1){1'b0}}, mism};
          end
`endif
        end
        default: begin
          state_next = HUNT;
          fill_next  = 3'd0;
          run_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    bit_cnt_next = bit_cnt_reg;
    err_cnt_next = err_cnt_reg;
    bit_sat_next = bit_sat_reg;
    err_sat_next = err_sat_reg;
    if (clr) begin
      bit_cnt_next = '0;
      err_cnt_next = '0;
      bit_sat_next = 1'b0;
      err_sat_next = 1'b0;
    end else begin
      if (cnt_bit && !(&bit_cnt_reg)) bit_cnt_next = bit_cnt_reg + 1'b1;
      if (cnt_err && !(&err_cnt_reg)) err_cnt_next = err_cnt_reg + 1'b1;
      bit_sat_next = bit_sat_reg | (&bit_cnt_next);
      err_sat_next = err_sat_reg | (&err_cnt_next);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= HUNT;
      lf_reg        <= 7'd0;
      fill_reg      <= 3'd0;
      run_reg       <= '0;
      bit_cnt_reg   <= '0;
      err_cnt_reg   <= '0;
      bit_sat_reg   <= 1'b0;
      err_sat_reg   <= 1'b0;
      err_pulse_reg <= 1'b0;
`ifdef BER_LOS_EN
      win_reg       <= '0;
      win_err_reg   <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      lf_reg        <= lf_next;
      fill_reg      <= fill_next;
      run_reg       <= run_next;
      bit_cnt_reg   <= bit_cnt_next;
      err_cnt_reg   <= err_cnt_next;
      bit_sat_reg   <= bit_sat_next;
      err_sat_reg   <= err_sat_next;
      err_pulse_reg <= err_pulse_next;
`ifdef BER_LOS_EN
      win_reg       <= win_next;
      win_err_reg   <= win_err_next;
`endif
    end
  end

  assign locked    = (state_reg == LOCKED);
  assign err_pulse = err_pulse_reg;
  assign bit_cnt   = bit_cnt_reg;
  assign err_cnt   = err_cnt_reg;
  assign bit_sat   = bit_sat_reg;
  assign err_sat   = err_sat_reg;

endmodule

// File: tb/tb_prbs_ber_checker.sv
// Directed bench for prbs_ber_checker: lock, errors, reset, gaps, loss of sync, saturation.
// Expectations for loss of sync follow BER_LOS_EN.
module tb_prbs_ber_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic        din_vld = 1'b0;
  logic        clr = 1'b0;
  logic        clr4 = 1'b0;
  logic        locked, err_pulse, bit_sat, err_sat;
  logic [31:0] bit_cnt, err_cnt;
  logic        locked4, err_pulse4, bit_sat4, err_sat4;
  logic [3:0]  bit_cnt4, err_cnt4;

  int checks = 0;
  int errors = 0;
  logic [6:0] gen = 7'h7F;

  always #5 clk = ~clk;

  prbs_ber_checker dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .bit_cnt(bit_cnt), .err_cnt(err_cnt),
    .bit_sat(bit_sat), .err_sat(err_sat)
  );

  prbs_ber_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .clr(clr4),
    .locked(locked4), .err_pulse(err_pulse4), .bit_cnt(bit_cnt4), .err_cnt(err_cnt4),
    .bit_sat(bit_sat4), .err_sat(err_sat4)
  );

  // Drive one cycle and return #1 after the rising edge.
  task automatic send(input logic b, input logic v);
    din = b;
    din_vld = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send_prbs(input logic flip);
    logic b;
    b = gen[6] ^ gen[5];
    gen = {gen[5:0], b};
    send(b ^ flip, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    gen = 7'h7F;
  endtask

  // Sends 23 clean bits and checks lock appears exactly on the last one.
  task automatic acquire(input string tag);
    for (int i = 0; i < 22; i++) send_prbs(1'b0);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL %s_early_lock: got %b want 0", tag, locked); end
    send_prbs(1'b0);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL %s_lock: got %b want 1", tag, locked); end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({locked, err_pulse, bit_sat, err_sat} !== 4'b0 || bit_cnt !== 32'd0 || err_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: got lk=%b ep=%b bc=%0d ec=%0d bs=%b es=%b want all 0",
               locked, err_pulse, bit_cnt, err_cnt, bit_sat, err_sat);
    end
    $display("test_reset done");
  endtask

  task automatic test_clean_lock();
    int pulses;
    acquire("clean");
    checks++;
    if (bit_cnt !== 32'd0) begin errors++; $display("FAIL lock_bit_uncounted: got %0d want 0", bit_cnt); end
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      send_prbs(1'b0);
      if (err_pulse) pulses++;
    end
    checks++;
    if (bit_cnt !== 32'd1000) begin errors++; $display("FAIL clean_bit_cnt: got %0d want 1000", bit_cnt); end
    checks++;
    if (err_cnt !== 32'd0) begin errors++; $display("FAIL clean_err_cnt: got %0d want 0", err_cnt); end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL clean_pulses: got %0d want 0", pulses); end
    $display("test_clean_lock done: bit_cnt=%0d", bit_cnt);
  endtask

  task automatic test_single_error();
    send_prbs(1'b1);
    checks++;
    if (err_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse: got %b want 1", err_pulse); end
    checks++;
    if (err_cnt !== 32'd1) begin errors++; $display("FAIL single_err_cnt: got %0d want 1", err_cnt); end
    send_prbs(1'b0);
    checks++;
    if (err_pulse !== 1'b0) begin errors++; $display("FAIL single_pulse_width: got %b want 0", err_pulse); end
    for (int i = 0; i < 99; i++) send_prbs(1'b0);
    checks++;
    if (err_cnt !== 32'd1 || bit_cnt !== 32'd1101 || locked !== 1'b1) begin
      errors++;
      $display("FAIL single_after: got ec=%0d bc=%0d lk=%b want 1 1101 1", err_cnt, bit_cnt, locked);
    end
    $display("test_single_error done: err_cnt=%0d", err_cnt);
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    #2;
    checks++;
    if ({locked, err_pulse, bit_sat, err_sat} !== 4'b0 || bit_cnt !== 32'd0 || err_cnt !== 32'd0 ||
        bit_cnt4 !== 4'd0 || bit_sat4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got lk=%b bc=%0d ec=%0d bc4=%0d bs4=%b want all 0",
               locked, bit_cnt, err_cnt, bit_cnt4, bit_sat4);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    acquire("relock_after_rst");
    $display("test_reset_mid done");
  endtask

  task automatic test_zeros();
    int seen;
    do_reset();
    seen = 0;
    for (int i = 0; i < 500; i++) begin
      send(1'b0, 1'b1);
      if (locked) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL zeros_locked: got %0d locked cycles want 0", seen); end
    $display("test_zeros done");
  endtask

  task automatic test_gaps();
    do_reset();
    for (int i = 0; i < 22; i++) begin
      send_prbs(1'b0);
      send(1'($urandom_range(1)), 1'b0);
    end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL gaps_early: got %b want 0", locked); end
    send_prbs(1'b0);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL gaps_lock: got %b want 1", locked); end
    send(1'b1, 1'b0);
    checks++;
    if (locked !== 1'b1 || bit_cnt !== 32'd0) begin
      errors++;
      $display("FAIL gaps_hold: got lk=%b bc=%0d want 1 0", locked, bit_cnt);
    end
    $display("test_gaps done");
  endtask

  task automatic test_los();
    do_reset();
    acquire("los_pre");
    for (int i = 0; i < 20; i++) send_prbs(1'b0);
    for (int e = 0; e < 7; e++) begin
      send_prbs(1'b1);
      send_prbs(1'b0);
      send_prbs(1'b0);
    end
    checks++;
    if (locked !== 1'b1 || err_cnt !== 32'd7) begin
      errors++;
      $display("FAIL los_seven: got lk=%b ec=%0d want 1 7", locked, err_cnt);
    end
    send_prbs(1'b1);
    checks++;
    if (err_cnt !== 32'd8 || bit_cnt !== 32'd42 || err_pulse !== 1'b1) begin
      errors++;
      $display("FAIL los_eighth: got ec=%0d bc=%0d ep=%b want 8 42 1", err_cnt, bit_cnt, err_pulse);
    end
`ifdef BER_LOS_EN
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL los_drop: got %b want 0", locked); end
    acquire("los_relock");
    checks++;
    if (err_cnt !== 32'd8 || bit_cnt !== 32'd42) begin
      errors++;
      $display("FAIL los_held: got ec=%0d bc=%0d want 8 42", err_cnt, bit_cnt);
    end
`else
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL nolos_stay: got %b want 1", locked); end
    for (int i = 0; i < 23; i++) send_prbs(1'b0);
    checks++;
    if (locked !== 1'b1 || err_cnt !== 32'd8 || bit_cnt !== 32'd65) begin
      errors++;
      $display("FAIL nolos_after: got lk=%b ec=%0d bc=%0d want 1 8 65", locked, err_cnt, bit_cnt);
    end
`endif
    $display("test_los done: err_cnt=%0d", err_cnt);
  endtask

  task automatic test_saturation();
    do_reset();
    acquire("sat_pre");
    for (int i = 0; i < 14; i++) send_prbs(1'b0);
    checks++;
    if (bit_cnt4 !== 4'd14 || bit_sat4 !== 1'b0) begin
      errors++;
      $display("FAIL sat_14: got bc4=%0d bs4=%b want 14 0", bit_cnt4, bit_sat4);
    end
    for (int i = 0; i < 6; i++) send_prbs(1'b0);
    checks++;
    if (bit_cnt4 !== 4'd15 || bit_sat4 !== 1'b1 || err_sat4 !== 1'b0) begin
      errors++;
      $display("FAIL sat_20: got bc4=%0d bs4=%b es4=%b want 15 1 0", bit_cnt4, bit_sat4, err_sat4);
    end
    clr4 = 1'b1;
    send_prbs(1'b0);
    clr4 = 1'b0;
    checks++;
    if (bit_cnt4 !== 4'd0 || bit_sat4 !== 1'b0 || locked4 !== 1'b1) begin
      errors++;
      $display("FAIL sat_clr: got bc4=%0d bs4=%b lk4=%b want 0 0 1", bit_cnt4, bit_sat4, locked4);
    end
    checks++;
    if (bit_cnt !== 32'd21) begin errors++; $display("FAIL clr_isolated: got %0d want 21", bit_cnt); end
    send_prbs(1'b0);
    checks++;
    if (bit_cnt4 !== 4'd1) begin errors++; $display("FAIL sat_after_clr: got %0d want 1", bit_cnt4); end
    $display("test_saturation done");
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_single_error();
    test_reset_mid();
    test_zeros();
    test_gaps();
    test_los();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
